// File: rtl/a_inv_stream_tx_pkg.sv
// Shared definitions for the inverse-result transmit path.
// Holds entry/tag widths, the FSM state encoding, the word index map
// (A11, A12, A21, A22) and the packed payload of one outgoing word.
package a_inv_stream_tx_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned TAG_W     = 8;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned NUM_WORDS = 4;

  // Transmit FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Word order on the stream
  localparam logic [IDX_W-1:0] IDX_A11  = 2'd0;
  localparam logic [IDX_W-1:0] IDX_A12  = 2'd1;
  localparam logic [IDX_W-1:0] IDX_A21  = 2'd2;
  localparam logic [IDX_W-1:0] IDX_A22  = 2'd3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_A22;

  // One word as presented on the output interface
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic [TAG_W-1:0]  tag;
  } tx_word_t;

  // Saturating increment used by the dropped-frame counter
  function automatic logic [TAG_W-1:0] sat_inc(input logic [TAG_W-1:0] v);
    return (v == {TAG_W{1'b1}}) ? v : v + TAG_W'(1);
  endfunction

endpackage : a_inv_stream_tx_pkg

// File: rtl/a_inv_rise_det.sv
// Rising-edge detector for the level valid from the inverse latch.
// Ports:
//   i_clk     - clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_valid   - level valid input
//   o_rise_c  - combinational: i_valid high while last sample was low
// The previous sample resets low, so a valid that is already high when
// reset releases reports a rise in the first active cycle.
module a_inv_rise_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_rise_c
);

  logic r_valid_d;

  // Previous-cycle sample of valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_d <= 1'b0;
    end else begin
      r_valid_d <= i_valid;
    end
  end

  assign o_rise_c = i_valid & ~r_valid_d;

endmodule : a_inv_rise_det

// File: rtl/a_inv_stream_tx.sv
// Transmit side of the latched 2x2 inverse result.
// Captures the four held entries on a rising edge of I_A_inv_valid and
// streams them as A11, A12, A21, A22 over a valid/ready interface, tagging
// each frame with a wrapping sequence number. A rise that arrives while a
// frame is still in flight (and not on its final accept) is dropped and
// reported through O_overrun / O_overrun_cnt.
// Ports:
//   I_sys_clk, I_sys_rstn         - clock, async active-low reset
//   I_A11..I_A22_inv_final        - held inverse entries
//   I_A_inv_valid                 - level valid for the entries
//   I_tx_ready                    - downstream ready
//   O_tx_valid/data/idx/last/tag  - outgoing word (all registered)
//   O_busy                        - frame in flight (mirrors O_tx_valid)
//   O_overrun                     - one-cycle pulse per dropped frame
//   O_overrun_cnt                 - saturating dropped-frame count
module a_inv_stream_tx
  import a_inv_stream_tx_pkg::*;
(
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic [DATA_W-1:0] I_A11_inv_final,
  input  logic [DATA_W-1:0] I_A12_inv_final,
  input  logic [DATA_W-1:0] I_A21_inv_final,
  input  logic [DATA_W-1:0] I_A22_inv_final,
  input  logic              I_A_inv_valid,
  input  logic              I_tx_ready,
  output logic              O_tx_valid,
  output logic [DATA_W-1:0] O_tx_data,
  output logic [IDX_W-1:0]  O_tx_idx,
  output logic              O_tx_last,
  output logic [TAG_W-1:0]  O_tx_tag,
  output logic              O_busy,
  output logic              O_overrun,
  output logic [TAG_W-1:0]  O_overrun_cnt
);

  logic              w_rise;
  logic              w_accept;
  logic              w_final;
  logic              w_capture;
  logic              w_drop;
  logic [IDX_W-1:0]  w_idx_inc;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_buf [NUM_WORDS];

  tx_word_t          r_word;
  tx_word_t          w_word_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;
  logic [TAG_W-1:0]  r_frame_cnt;
  logic [TAG_W-1:0]  w_frame_cnt_nxt;
  logic              r_ovr;
  logic              w_ovr_nxt;
  logic [TAG_W-1:0]  r_ovr_cnt;
  logic [TAG_W-1:0]  w_ovr_cnt_nxt;

  // Valid edge detection
  a_inv_rise_det u_rise_det (
    .i_clk    (I_sys_clk),
    .i_rst_n  (I_sys_rstn),
    .i_valid  (I_A_inv_valid),
    .o_rise_c (w_rise)
  );

  // Handshake and frame-admission decisions
  assign w_accept  = r_tx_valid & I_tx_ready;
  assign w_final   = w_accept & (r_word.idx == IDX_LAST);
  // A rise on the last accept starts the next frame back-to-back
  assign w_capture = w_rise & ((r_state == ST_IDLE) | w_final);
  assign w_drop    = w_rise & (r_state == ST_SEND) & ~w_final;
  assign w_idx_inc = r_word.idx + IDX_W'(1);

  // State register
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_final && !w_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    w_word_nxt      = r_word;
    w_tx_valid_nxt  = r_tx_valid;
    w_frame_cnt_nxt = r_frame_cnt;
    w_ovr_nxt       = 1'b0;
    w_ovr_cnt_nxt   = r_ovr_cnt;

    if (w_capture) begin
      // First word comes straight from the inputs; the buffer loads in parallel
      w_tx_valid_nxt  = 1'b1;
      w_word_nxt.data = I_A11_inv_final;
      w_word_nxt.idx  = IDX_A11;
      w_word_nxt.last = 1'b0;
      w_word_nxt.tag  = r_frame_cnt;
      w_frame_cnt_nxt = r_frame_cnt + TAG_W'(1);
    end else if (w_final) begin
      w_tx_valid_nxt  = 1'b0;
      w_word_nxt.idx  = IDX_A11;
      w_word_nxt.last = 1'b0;
    end else if (w_accept) begin
      w_word_nxt.data = r_buf[w_idx_inc];
      w_word_nxt.idx  = w_idx_inc;
      w_word_nxt.last = (w_idx_inc == IDX_LAST);
    end

    if (w_drop) begin
      w_ovr_nxt     = 1'b1;
      w_ovr_cnt_nxt = sat_inc(r_ovr_cnt);
    end
  end

  // Output and counter registers
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_word      <= '0;
      r_tx_valid  <= 1'b0;
      r_frame_cnt <= '0;
      r_ovr       <= 1'b0;
      r_ovr_cnt   <= '0;
    end else begin
      r_word      <= w_word_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_ovr       <= w_ovr_nxt;
      r_ovr_cnt   <= w_ovr_cnt_nxt;
    end
  end

  // Frame buffer; only written when a frame is admitted
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      r_buf[IDX_A11] <= I_A11_inv_final;
      r_buf[IDX_A12] <= I_A12_inv_final;
      r_buf[IDX_A21] <= I_A21_inv_final;
      r_buf[IDX_A22] <= I_A22_inv_final;
    end
  end

  assign O_tx_valid    = r_tx_valid;
  assign O_tx_data     = r_word.data;
  assign O_tx_idx      = r_word.idx;
  assign O_tx_last     = r_word.last;
  assign O_tx_tag      = r_word.tag;
  assign O_busy        = r_tx_valid;
  assign O_overrun     = r_ovr;
  assign O_overrun_cnt = r_ovr_cnt;

endmodule : a_inv_stream_tx

// File: tb/tb_a_inv_stream_tx.sv
// Self-checking bench for a_inv_stream_tx.
// A queue-based model holds the words still owed downstream; every cycle
// the DUT outputs are compared to the head of that queue. Directed
// scenarios add literal checks on the words actually transferred.
module tb_a_inv_stream_tx;

  logic        clk;
  logic        rst_n;
  logic [63:0] a11, a12, a21, a22;
  logic        a_valid;
  logic        tx_ready;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic [1:0]  tx_idx;
  logic        tx_last;
  logic [7:0]  tx_tag;
  logic        busy;
  logic        overrun;
  logic [7:0]  overrun_cnt;

  a_inv_stream_tx dut (
    .I_sys_clk       (clk),
    .I_sys_rstn      (rst_n),
    .I_A11_inv_final (a11),
    .I_A12_inv_final (a12),
    .I_A21_inv_final (a21),
    .I_A22_inv_final (a22),
    .I_A_inv_valid   (a_valid),
    .I_tx_ready      (tx_ready),
    .O_tx_valid      (tx_valid),
    .O_tx_data       (tx_data),
    .O_tx_idx        (tx_idx),
    .O_tx_last       (tx_last),
    .O_tx_tag        (tx_tag),
    .O_busy          (busy),
    .O_overrun       (overrun),
    .O_overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
    logic [7:0]  tag;
  } word_t;

  word_t exp_q[$];
  word_t log_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_frame_cnt;
  logic       m_prev;
  logic       m_ovr;
  logic [7:0] m_ovr_cnt;
  bit         m_acc;
  bit         m_rise;
  word_t      m_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frames are queued as four words; a rise is admitted only when no
  // word remains owed after this edge's transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_frame_cnt = 8'd0;
      m_prev      = 1'b0;
      m_ovr       = 1'b0;
      m_ovr_cnt   = 8'd0;
    end else begin
      m_acc  = (exp_q.size() > 0) && tx_ready;
      m_rise = a_valid && !m_prev;
      m_prev = a_valid;
      if (tx_valid && tx_ready) begin
        m_w.data = tx_data; m_w.idx = tx_idx; m_w.last = tx_last; m_w.tag = tx_tag;
        log_q.push_back(m_w);
      end
      if (m_acc) void'(exp_q.pop_front());
      m_ovr = 1'b0;
      if (m_rise) begin
        if (exp_q.size() == 0) begin
          m_w.tag = m_frame_cnt;
          m_w.data = a11; m_w.idx = 2'd0; m_w.last = 1'b0; exp_q.push_back(m_w);
          m_w.data = a12; m_w.idx = 2'd1; exp_q.push_back(m_w);
          m_w.data = a21; m_w.idx = 2'd2; exp_q.push_back(m_w);
          m_w.data = a22; m_w.idx = 2'd3; m_w.last = 1'b1; exp_q.push_back(m_w);
          m_frame_cnt = m_frame_cnt + 8'd1;
        end else begin
          m_ovr = 1'b1;
          if (m_ovr_cnt != 8'hFF) m_ovr_cnt = m_ovr_cnt + 8'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("tx_valid", 64'(tx_valid), 64'(exp_q.size() > 0));
      check("busy", 64'(busy), 64'(exp_q.size() > 0));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr_cnt));
      if (exp_q.size() > 0) begin
        check("tx_data", tx_data, exp_q[0].data);
        check("tx_idx", 64'(tx_idx), 64'(exp_q[0].idx));
        check("tx_last", 64'(tx_last), 64'(exp_q[0].last));
        check("tx_tag", 64'(tx_tag), 64'(exp_q[0].tag));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tagname);
    check({tagname, "_valid"}, 64'(tx_valid), 64'd0);
    check({tagname, "_data"}, tx_data, 64'd0);
    check({tagname, "_idx"}, 64'(tx_idx), 64'd0);
    check({tagname, "_last"}, 64'(tx_last), 64'd0);
    check({tagname, "_tag"}, 64'(tx_tag), 64'd0);
    check({tagname, "_busy"}, 64'(busy), 64'd0);
    check({tagname, "_ovr"}, 64'(overrun), 64'd0);
    check({tagname, "_ovr_cnt"}, 64'(overrun_cnt), 64'd0);
  endtask

  // Literal check of one transferred frame in the log
  task automatic check_frame(input string name, input int base, input logic [63:0] d0,
                             input logic [63:0] d1, input logic [63:0] d2,
                             input logic [63:0] d3, input logic [7:0] tag);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    check({name, "_logsize"}, 64'(log_q.size() >= base + 4), 64'd1);
    if (log_q.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check({name, "_data"}, log_q[base+k].data, d[k]);
        check({name, "_idx"}, 64'(log_q[base+k].idx), 64'(k));
        check({name, "_last"}, 64'(log_q[base+k].last), 64'(k == 3));
        check({name, "_tag"}, 64'(log_q[base+k].tag), 64'(tag));
      end
    end
  endtask

  logic [15:0] rdy_pat;
  bit          found;

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; tx_ready = 1'b1;
    a11 = '0; a12 = '0; a21 = '0; a22 = '0;
    tick(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic frame with ready held high
    a11 = 64'h11; a12 = 64'h22; a21 = 64'h33; a22 = 64'h44; a_valid = 1'b1;
    tick(2);
    a_valid = 1'b0;
    tick(8);
    check("basic_count", 64'(log_q.size()), 64'd4);
    check_frame("basic", 0, 64'h11, 64'h22, 64'h33, 64'h44, 8'd0);

    // Backpressure; inputs dropped and zeroed right after the rise
    log_q.delete();
    a11 = 64'h55; a12 = 64'h66; a21 = 64'h77; a22 = 64'h88; a_valid = 1'b1;
    tick(1);
    a_valid = 1'b0; a11 = '0; a12 = '0; a21 = '0; a22 = '0;
    rdy_pat = 16'b0110_1001_1011_0011;
    for (int i = 0; i < 16; i++) begin
      tx_ready = rdy_pat[15-i];
      tick(1);
    end
    tx_ready = 1'b1;
    tick(6);
    check("bp_count", 64'(log_q.size()), 64'd4);
    check_frame("bp", 0, 64'h55, 64'h66, 64'h77, 64'h88, 8'd1);

    // Overrun: second rise while idx 1 is stalled
    log_q.delete();
    a11 = 64'hA1; a12 = 64'hA2; a21 = 64'hA3; a22 = 64'hA4; a_valid = 1'b1;
    tick(2);
    tx_ready = 1'b0; a_valid = 1'b0;
    tick(1);
    a_valid = 1'b1; a11 = 64'hDEAD;
    @(posedge clk); #2;
    check("ovr_pulse", 64'(overrun), 64'd1);
    check("ovr_cnt1", 64'(overrun_cnt), 64'd1);
    check("ovr_idx", 64'(tx_idx), 64'd1);
    tick(1);
    a_valid = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #2;
    check("ovr_pulse_end", 64'(overrun), 64'd0);
    tick(8);
    check("ovr_count", 64'(log_q.size()), 64'd4);
    check_frame("ovr", 0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 8'd2);
    a11 = 64'hB1; a12 = 64'hB2; a21 = 64'hB3; a22 = 64'hB4; a_valid = 1'b1;
    tick(1);
    a_valid = 1'b0;
    tick(8);
    check("after_ovr_count", 64'(log_q.size()), 64'd8);
    check_frame("after_ovr", 4, 64'hB1, 64'hB2, 64'hB3, 64'hB4, 8'd3);

    // 256 back-to-back frames; tags run 4..255, 0..3
    log_q.delete();
    for (int f = 0; f < 256; f++) begin
      a11 = {32'(f), 32'd0}; a12 = {32'(f), 32'd1};
      a21 = {32'(f), 32'd2}; a22 = {32'(f), 32'd3};
      a_valid = 1'b1;
      if (f > 0) begin
        check("b2b_valid", 64'(tx_valid), 64'd1);
        check("b2b_idx3", 64'(tx_idx), 64'd3);
      end
      tick(1);
      a_valid = 1'b0;
      tick(3);
    end
    tick(8);
    check("b2b_count", 64'(log_q.size()), 64'd1024);
    check_frame("b2b_first", 0, {32'd0, 32'd0}, {32'd0, 32'd1}, {32'd0, 32'd2}, {32'd0, 32'd3}, 8'd4);
    check_frame("b2b_255", 4*251, {32'd251, 32'd0}, {32'd251, 32'd1}, {32'd251, 32'd2}, {32'd251, 32'd3}, 8'd255);
    check_frame("b2b_wrap", 4*252, {32'd252, 32'd0}, {32'd252, 32'd1}, {32'd252, 32'd2}, {32'd252, 32'd3}, 8'd0);
    check_frame("b2b_end", 4*255, {32'd255, 32'd0}, {32'd255, 32'd1}, {32'd255, 32'd2}, {32'd255, 32'd3}, 8'd3);
    check("b2b_ovr_cnt", 64'(overrun_cnt), 64'd1);

    // Reset during idx 2, valid held high across release
    a11 = 64'hC1; a12 = 64'hC2; a21 = 64'hC3; a22 = 64'hC4; a_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_idx == 2'd2) found = 1'b1;
    end
    check("rst_reach_idx2", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    tick(2);
    log_q.delete();
    rst_n = 1'b1;
    tick(8);
    check("postrst_count", 64'(log_q.size()), 64'd4);
    check_frame("postrst", 0, 64'hC1, 64'hC2, 64'hC3, 64'hC4, 8'd0);
    a_valid = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_a_inv_stream_tx
